// File: rtl/regfile_ecc_checker.sv
// Two-stage SEC-DED (39,32) checker: stage 1 forms syndrome and overall parity,
// stage 2 corrects single-bit errors, flags double errors and feeds saturating counters.
module regfile_ecc_checker #(
  parameter int WORD_SIZE   = 32,
  parameter int ECCBITS     = 7,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [WORD_SIZE-1:0]   data_i,
  input  logic [ECCBITS-1:0]     ecc_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [WORD_SIZE-1:0]   data_o,
  output logic [1:0]             status_o,
  input  logic                   clear_i,
  output logic [COUNT_WIDTH-1:0] corr_count_o,
  output logic [COUNT_WIDTH-1:0] uncorr_count_o,
  output logic                   err_pulse_o
);

  localparam logic [1:0] ST_CLEAN  = 2'b00;
  localparam logic [1:0] ST_CORR   = 2'b01;
  localparam logic [1:0] ST_UNCORR = 2'b10;

  // Codeword position of data bit idx: the idx-th non-power-of-two in 1..38.
  function automatic int f_pos(input int idx);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) res = p;
        cnt++;
      end
    end
    return res;
  endfunction

  logic                   w_adv;
  logic [5:0]             w_contrib [WORD_SIZE];
  logic [WORD_SIZE-1:0]   w_flip;
  logic [5:0]             w_syn;
  logic                   w_par;
  logic [WORD_SIZE-1:0]   w_data2;
  logic [1:0]             w_stat2;
  logic                   w_hs;

  logic                   r_v1;
  logic [WORD_SIZE-1:0]   r_d1;
  logic [5:0]             r_s1;
  logic                   r_p1;
  logic                   r_v2;
  logic [WORD_SIZE-1:0]   r_d2;
  logic [1:0]             r_st2;
  logic [COUNT_WIDTH-1:0] r_corr;
  logic [COUNT_WIDTH-1:0] r_uncorr;
  logic                   r_err;

  assign w_adv   = !r_v2 || ready_i;
  assign ready_o = w_adv;
  assign w_hs    = r_v2 && ready_i;

  for (genvar gi = 0; gi < WORD_SIZE; gi++) begin : g_map
    localparam logic [5:0] LP_POS = 6'(f_pos(gi));
    assign w_contrib[gi] = data_i[gi] ? LP_POS : 6'd0;
    assign w_flip[gi]    = (r_s1 == LP_POS);
  end

  always_comb begin
    w_syn = ecc_i[5:0];
    for (int i = 0; i < WORD_SIZE; i++) w_syn = w_syn ^ w_contrib[i];
    w_par = ^{data_i, ecc_i};
  end

  // Syndromes 3..38 that are not powers of two name exactly one data bit, so
  // w_flip is all-zero for a check-bit error and the XOR leaves data intact.
  always_comb begin
    w_data2 = r_d1;
    w_stat2 = ST_CLEAN;
    if (r_p1) begin
      if (r_s1 > 6'd38) begin
        w_stat2 = ST_UNCORR;
      end else begin
        w_stat2 = ST_CORR;
        w_data2 = r_d1 ^ w_flip;
      end
    end else if (r_s1 != 6'd0) begin
      w_stat2 = ST_UNCORR;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_v1  <= 1'b0;
      r_d1  <= '0;
      r_s1  <= '0;
      r_p1  <= 1'b0;
      r_v2  <= 1'b0;
      r_d2  <= '0;
      r_st2 <= ST_CLEAN;
    end else if (w_adv) begin
      r_v1  <= valid_i;
      r_d1  <= data_i;
      r_s1  <= w_syn;
      r_p1  <= w_par;
      r_v2  <= r_v1;
      r_d2  <= w_data2;
      r_st2 <= w_stat2;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_corr   <= '0;
      r_uncorr <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_hs && (r_st2 == ST_UNCORR);
      if (clear_i) begin
        r_corr   <= '0;
        r_uncorr <= '0;
      end else begin
        if (w_hs && (r_st2 == ST_CORR) && (r_corr != '1))
          r_corr <= r_corr + 1'b1;
        if (w_hs && (r_st2 == ST_UNCORR) && (r_uncorr != '1))
          r_uncorr <= r_uncorr + 1'b1;
      end
    end
  end

  assign valid_o        = r_v2;
  assign data_o         = r_d2;
  assign status_o       = r_st2;
  assign corr_count_o   = r_corr;
  assign uncorr_count_o = r_uncorr;
  assign err_pulse_o    = r_err;

endmodule

// File: tb/tb_regfile_ecc_checker.sv
// Directed bench for regfile_ecc_checker (COUNT_WIDTH=2 so saturation is reachable);
// an output monitor checks word order and stall stability against an expected queue.
module tb_regfile_ecc_checker;

  logic        clk;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_i;
  logic [6:0]  ecc_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data_o;
  logic [1:0]  status_o;
  logic        clear_i;
  logic [1:0]  corr_count_o;
  logic [1:0]  uncorr_count_o;
  logic        err_pulse_o;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [33:0] exp_q[$];

  regfile_ecc_checker #(.WORD_SIZE(32), .ECCBITS(7), .COUNT_WIDTH(2)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .data_i         (data_i),
    .ecc_i          (ecc_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .data_o         (data_o),
    .status_o       (status_o),
    .clear_i        (clear_i),
    .corr_count_o   (corr_count_o),
    .uncorr_count_o (uncorr_count_o),
    .err_pulse_o    (err_pulse_o)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) tick();
  endtask

  // Presents one word until accepted; ready_o is sampled mid-cycle.
  task automatic send(input logic [31:0] d, input logic [6:0] e,
                      input logic [1:0] st, input logic [31:0] dexp);
    bit acc;
    int waited;
    valid_i = 1'b1;
    data_i  = d;
    ecc_i   = e;
    exp_q.push_back({st, dexp});
    acc    = 1'b0;
    waited = 0;
    while (!acc && waited < 20) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      waited++;
    end
    n_cmp++;
    assert (acc) else begin
      n_fail++;
      $error("FAIL send_timeout: observed ready_o=0 for %0d cycles, required acceptance", waited);
    end
    valid_i = 1'b0;
  endtask

  // scoreboard / stability monitor
  bit          m_hold = 1'b0;
  logic [31:0] m_hold_d;
  logic [1:0]  m_hold_s;
  logic [33:0] m_e;

  always @(negedge clk) begin
    if (rst_ni) begin
      if (m_hold && valid_o) begin
        chk("hold_data", data_o, m_hold_d);
        chk("hold_status", 32'(status_o), 32'(m_hold_s));
      end
      m_hold   = valid_o && !ready_i;
      m_hold_d = data_o;
      m_hold_s = status_o;
      if (valid_o && ready_i) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_word: observed data %0h with empty expected queue", data_o);
        end
        if (exp_q.size() != 0) begin
          m_e = exp_q.pop_front();
          chk("out_data", data_o, m_e[31:0]);
          chk("out_status", 32'(status_o), 32'(m_e[33:32]));
        end
      end
    end else begin
      m_hold = 1'b0;
    end
  end

  initial begin
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    clear_i = 1'b0;
    data_i  = '0;
    ecc_i   = '0;
    #3;
    chk("rst_valid_o", 32'(valid_o), 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_status_o", 32'(status_o), 0);
    chk("rst_corr", 32'(corr_count_o), 0);
    chk("rst_uncorr", 32'(uncorr_count_o), 0);
    chk("rst_err_pulse", 32'(err_pulse_o), 0);
    chk("rst_ready_o", 32'(ready_o), 1);
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;

    // clean word, latency 2
    send(32'h0, 7'h00, 2'b00, 32'h0);
    chk("lat_not_yet", 32'(valid_o), 0);
    tick();
    chk("lat_valid_o", 32'(valid_o), 1);
    chk("clean_data", data_o, 0);
    chk("clean_status", 32'(status_o), 0);
    idle(3);
    chk("clean_corr", 32'(corr_count_o), 0);
    chk("clean_uncorr", 32'(uncorr_count_o), 0);

    // single data-bit error at position 3
    send(32'h1, 7'h00, 2'b01, 32'h0);
    idle(3);
    chk("sbe_corr", 32'(corr_count_o), 1);

    // check-bit errors: ecc[0] and ecc[6]
    send(32'h0, 7'h01, 2'b01, 32'h0);
    send(32'h0, 7'h40, 2'b01, 32'h0);
    idle(3);
    chk("chk_err_corr", 32'(corr_count_o), 3);
    chk("chk_err_uncorr", 32'(uncorr_count_o), 0);

    // double error s=6 p=0, with err pulse timing
    send(32'h3, 7'h00, 2'b10, 32'h3);
    chk("pulse_early0", 32'(err_pulse_o), 0);
    tick();
    chk("pulse_early1", 32'(err_pulse_o), 0);
    tick();
    chk("pulse_high", 32'(err_pulse_o), 1);
    chk("dbe_uncorr", 32'(uncorr_count_o), 1);
    tick();
    chk("pulse_low", 32'(err_pulse_o), 0);
    chk("corr_saturated", 32'(corr_count_o), 3);

    // boundaries: s=38 flips bit 31; s=39 with p=1 and p=0; s=63; clean nonzero words
    send(32'h0,        7'h26, 2'b01, 32'h8000_0000);
    send(32'h8000_0000, 7'h26, 2'b00, 32'h8000_0000);
    send(32'h0,        7'h67, 2'b10, 32'h0);
    send(32'h0,        7'h27, 2'b10, 32'h0);
    send(32'h0,        7'h7F, 2'b10, 32'h0);
    send(32'h1,        7'h43, 2'b00, 32'h1);
    idle(4);
    chk("uncorr_saturated", 32'(uncorr_count_o), 3);
    chk("corr_still_sat", 32'(corr_count_o), 3);

    // synchronous clear
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clear_corr", 32'(corr_count_o), 0);
    chk("clear_uncorr", 32'(uncorr_count_o), 0);

    // backpressure: ready_i low for 3 cycles while 4 words stream
    fork
      begin
        send(32'h0, 7'h00, 2'b00, 32'h0);
        send(32'h1, 7'h43, 2'b00, 32'h1);
        send(32'h0, 7'h26, 2'b01, 32'h8000_0000);
        send(32'h0, 7'h7F, 2'b10, 32'h0);
      end
      begin
        repeat (2) tick();
        ready_i = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_ready_o", 32'(ready_o), 0);
          @(posedge clk);
          #1;
        end
        ready_i = 1'b1;
      end
    join
    idle(6);
    chk("bp_corr", 32'(corr_count_o), 1);
    chk("bp_uncorr", 32'(uncorr_count_o), 1);
    chk("bp_queue_drained", exp_q.size(), 0);

    // saturation: 5 more corrected words
    repeat (5) send(32'h1, 7'h00, 2'b01, 32'h0);
    idle(4);
    chk("sat_corr", 32'(corr_count_o), 3);

    // clear in the same cycle as a corrected handshake
    send(32'h1, 7'h00, 2'b01, 32'h0);
    tick();
    chk("clr_hs_valid", 32'(valid_o), 1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clear_wins", 32'(corr_count_o), 0);
    tick();
    chk("clear_wins_after", 32'(corr_count_o), 0);

    // reset mid-stream
    send(32'h1, 7'h00, 2'b01, 32'h0);
    send(32'h1, 7'h00, 2'b01, 32'h0);
    send(32'h1, 7'h00, 2'b01, 32'h0);
    chk("pre_rst_corr", 32'(corr_count_o), 1);
    chk("pre_rst_valid", 32'(valid_o), 1);
    rst_ni = 1'b0;
    #1;
    chk("midrst_valid_o", 32'(valid_o), 0);
    chk("midrst_corr", 32'(corr_count_o), 0);
    chk("midrst_uncorr", 32'(uncorr_count_o), 0);
    chk("midrst_ready_o", 32'(ready_o), 1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    idle(4);
    chk("post_rst_valid", 32'(valid_o), 0);
    chk("post_rst_corr", 32'(corr_count_o), 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
